// File: rtl/video_frame_checker.sv
// video_frame_checker: in-line TFT stream monitor checking line/frame geometry and
// producing a per-frame CRC-32 and frame count over a programmed number of frames.
module video_frame_checker #(
  parameter int pColorWidth    = 4,
  parameter int pHdisplayWidth = 11,
  parameter int pVdisplayWidth = 11,
  parameter int pFrameCntWidth = 8
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic [pColorWidth-1:0]    iColorR,
  input  logic [pColorWidth-1:0]    iColorG,
  input  logic [pColorWidth-1:0]    iColorB,
  input  logic                      iVde,
  input  logic                      iAFE,
  input  logic [pHdisplayWidth:0]   iHdisplay,
  input  logic [pVdisplayWidth:0]   iVdisplay,
  input  logic                      iStart,
  input  logic [pFrameCntWidth-1:0] iFrameTarget,
  output logic                      oBusy,
  output logic                      oDone,
  output logic                      oFrameDone,
  output logic [31:0]               oCrc,
  output logic [pFrameCntWidth-1:0] oFrameCnt,
  output logic [pVdisplayWidth:0]   oLineCnt,
  output logic                      oErrH,
  output logic                      oErrV
);
  localparam int CW = 3 * pColorWidth;
  localparam int HW = pHdisplayWidth + 1;
  localparam int VW = pVdisplayWidth + 1;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] INIT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {IDLE, SYNC, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic                      vde_q, vde_d;
  logic [HW-1:0]             pix_q, pix_d, pix_inc, pix_fin;
  logic [VW-1:0]             line_q, line_d, line_inc, line_fin;
  logic [VW-1:0]             line_out_q, line_out_d;
  logic [31:0]               crc_q, crc_d, crc_fin, crc_out_q, crc_out_d;
  logic [pFrameCntWidth-1:0] fcnt_q, fcnt_d, fcnt_inc;
  logic                      err_h_q, err_h_d, err_v_q, err_v_d;
  logic                      fdone_q, fdone_d, line_end;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [CW-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = CW - 1; i >= 0; i--) r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY : 32'h0);
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    vde_d      = 1'b0;
    pix_d      = '0;
    line_d     = '0;
    crc_d      = INIT;
    crc_out_d  = crc_out_q;
    line_out_d = line_out_q;
    fcnt_d     = fcnt_q;
    err_h_d    = err_h_q;
    err_v_d    = err_v_q;
    fdone_d    = 1'b0;
    pix_inc    = (&pix_q) ? pix_q : pix_q + 1'b1;
    line_inc   = (&line_q) ? line_q : line_q + 1'b1;
    line_end   = (vde_q & ~iVde) | (iAFE & iVde);
    pix_fin    = iVde ? pix_inc : pix_q;
    line_fin   = line_end ? line_inc : line_q;
    crc_fin    = iVde ? crc_upd(crc_q, {iColorR, iColorG, iColorB}) : crc_q;
    fcnt_inc   = fcnt_q + 1'b1;
    case (state_q)
      IDLE, DONE: if (iStart) begin
        state_d = SYNC;
        fcnt_d  = '0;
        err_h_d = 1'b0;
        err_v_d = 1'b0;
      end
      SYNC: if (iAFE) state_d = RUN;
      RUN: begin
        // a line closed by iAFE must not see a second close on the next falling edge
        vde_d   = iVde & ~iAFE;
        pix_d   = line_end ? '0 : pix_fin;
        line_d  = iAFE ? '0 : line_fin;
        crc_d   = iAFE ? INIT : crc_fin;
        err_h_d = err_h_q | (line_end & (pix_fin != iHdisplay));
        if (iAFE) begin
          err_v_d    = err_v_q | (line_fin != iVdisplay);
          crc_out_d  = crc_fin ^ INIT;
          line_out_d = line_fin;
          fcnt_d     = fcnt_inc;
          fdone_d    = 1'b1;
          state_d    = (iFrameTarget != '0 && fcnt_inc == iFrameTarget) ? DONE : RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q    <= IDLE;
      vde_q      <= 1'b0;
      pix_q      <= '0;
      line_q     <= '0;
      line_out_q <= '0;
      crc_q      <= INIT;
      crc_out_q  <= '0;
      fcnt_q     <= '0;
      err_h_q    <= 1'b0;
      err_v_q    <= 1'b0;
      fdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      vde_q      <= vde_d;
      pix_q      <= pix_d;
      line_q     <= line_d;
      line_out_q <= line_out_d;
      crc_q      <= crc_d;
      crc_out_q  <= crc_out_d;
      fcnt_q     <= fcnt_d;
      err_h_q    <= err_h_d;
      err_v_q    <= err_v_d;
      fdone_q    <= fdone_d;
    end
  end

  assign oBusy      = (state_q == SYNC) || (state_q == RUN);
  assign oDone      = state_q == DONE;
  assign oFrameDone = fdone_q;
  assign oCrc       = crc_out_q;
  assign oFrameCnt  = fcnt_q;
  assign oLineCnt   = line_out_q;
  assign oErrH      = err_h_q;
  assign oErrV      = err_v_q;
endmodule

// File: tb/tb_video_frame_checker.sv
// tb_video_frame_checker: randomized frames scored against a per-frame CRC/geometry model.
module tb_video_frame_checker;
  logic        iClk = 1'b0, iRst = 1'b0;
  logic [3:0]  iColorR = '0, iColorG = '0, iColorB = '0;
  logic        iVde = 1'b0, iAFE = 1'b0, iStart = 1'b0;
  logic [11:0] iHdisplay = '0, iVdisplay = '0;
  logic [7:0]  iFrameTarget = '0;
  logic        oBusy, oDone, oFrameDone, oErrH, oErrV;
  logic [31:0] oCrc;
  logic [7:0]  oFrameCnt;
  logic [11:0] oLineCnt;

  typedef struct {logic [31:0] crc; logic [11:0] lines; logic [7:0] fc; logic eh; logic ev;} exp_t;
  typedef logic [11:0] wq_t[$];

  exp_t       sb[$];
  int         lens[$];
  int         total = 0, bad = 0, npulse = 0;
  logic [7:0] m_fc;
  logic       m_eh, m_ev;

  always #5 iClk = ~iClk;

  video_frame_checker dut (
    .iClk(iClk), .iRst(iRst), .iColorR(iColorR), .iColorG(iColorG), .iColorB(iColorB),
    .iVde(iVde), .iAFE(iAFE), .iHdisplay(iHdisplay), .iVdisplay(iVdisplay), .iStart(iStart),
    .iFrameTarget(iFrameTarget), .oBusy(oBusy), .oDone(oDone), .oFrameDone(oFrameDone),
    .oCrc(oCrc), .oFrameCnt(oFrameCnt), .oLineCnt(oLineCnt), .oErrH(oErrH), .oErrV(oErrV)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // textbook MSB-first CRC-32 over the whole frame's pixel words
  function automatic logic [31:0] crc32(input wq_t w);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (w[i]) for (int b = 11; b >= 0; b--) c = (c << 1) ^ ((c[31] ^ w[i][b]) ? 32'h04C11DB7 : 32'h0);
    return ~c;
  endfunction

  function automatic void mk(input int n, input int len);
    lens.delete();
    repeat (n) lens.push_back(len);
  endfunction

  task automatic start(input int tgt);
    @(negedge iClk);
    iStart = 1'b1;
    iFrameTarget = 8'(tgt);
    m_fc = '0;
    m_eh = 1'b0;
    m_ev = 1'b0;
    npulse = 0;
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  task automatic drive_frame(input int mode, input bit coinc, input bit checked, input int abort_line);
    wq_t w;
    logic [11:0] px;
    int nl = lens.size();
    bit co = coinc && nl > 0;
    exp_t e;
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < lens[l]; p++) begin
        @(negedge iClk);
        px = mode == 0 ? ((l < nl / 2) ? 12'h0F0 : 12'hFFF) : 12'($urandom);
        {iColorR, iColorG, iColorB} = px;
        iVde = 1'b1;
        w.push_back(px);
        if (co && l == nl - 1 && p == lens[l] - 1) iAFE = 1'b1;
        if (l == abort_line && p == lens[l] / 2) begin
          #2 iRst = 1'b0;
          #1 chk("abort_outputs_zero", {oBusy, oDone, oFrameDone, oCrc, oFrameCnt, oLineCnt, oErrH, oErrV}, '0);
          iVde = 1'b0;
          return;
        end
      end
      if (!(co && l == nl - 1)) repeat (2) begin
        @(negedge iClk);
        iVde = 1'b0;
        {iColorR, iColorG, iColorB} = 12'($urandom);
      end
    end
    if (!co) begin
      @(negedge iClk);
      iVde = 1'b0;
      iAFE = 1'b1;
    end
    if (checked) begin
      foreach (lens[i]) if (lens[i] != int'(iHdisplay)) m_eh = 1'b1;
      if (nl != int'(iVdisplay)) m_ev = 1'b1;
      m_fc++;
      e.crc = crc32(w);
      e.lines = 12'(nl);
      e.fc = m_fc;
      e.eh = m_eh;
      e.ev = m_ev;
      sb.push_back(e);
    end
    @(negedge iClk);
    iAFE = 1'b0;
    iVde = 1'b0;
    repeat (2) @(negedge iClk);
  endtask

  always @(negedge iClk) begin : mon
    exp_t e;
    if (iRst && oFrameDone) begin
      npulse++;
      if (sb.size() == 0) chk("unexpected_frame_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("frame_crc", oCrc, e.crc);
        chk("frame_lines", oLineCnt, e.lines);
        chk("frame_cnt", oFrameCnt, e.fc);
        chk("frame_errh", oErrH, e.eh);
        chk("frame_errv", oErrV, e.ev);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (5) begin
      @(negedge iClk);
      {iColorR, iColorG, iColorB, iVde, iAFE, iStart} = 15'($urandom);
      iHdisplay = 12'($urandom);
      iVdisplay = 12'($urandom);
      iFrameTarget = 8'($urandom);
      #1 chk("reset_outputs_zero", {oBusy, oDone, oFrameDone, oCrc, oFrameCnt, oLineCnt, oErrH, oErrV}, '0);
    end
    @(negedge iClk);
    {iColorR, iColorG, iColorB, iVde, iAFE, iStart} = '0;
    iHdisplay = 12'd4;
    iVdisplay = 12'd4;
    iRst = 1'b1;
    mk(4, 4);
    repeat (100) drive_frame(1, 0, 0, -1);
    chk("idle_no_pulse", npulse, 0);
    chk("idle_busy", oBusy, 0);

    iHdisplay = 12'd32;
    iVdisplay = 12'd32;
    start(4);
    chk("start_busy", oBusy, 1);
    mk(32, 32);
    drive_frame(0, 0, 0, -1);
    repeat (4) drive_frame(0, 0, 1, -1);
    chk("nom_pulses", npulse, 4);
    chk("nom_done", oDone, 1);
    chk("nom_busy", oBusy, 0);
    chk("nom_fcnt", oFrameCnt, 4);
    chk("nom_linecnt", oLineCnt, 32);
    chk("nom_sb_empty", sb.size(), 0);

    start(4);
    chk("restart_done_cleared", oDone, 0);
    drive_frame(1, 0, 0, -1);
    drive_frame(1, 0, 1, -1);
    lens[5] = 31;
    drive_frame(1, 0, 1, -1);
    lens[5] = 32;
    repeat (2) drive_frame(1, 0, 1, -1);
    chk("herr_sticky", oErrH, 1);
    chk("herr_verr", oErrV, 0);
    chk("herr_done", oDone, 1);

    start(2);
    chk("restart_errh_cleared", oErrH, 0);
    drive_frame(1, 0, 0, -1);
    mk(33, 32);
    drive_frame(1, 0, 1, -1);
    mk(32, 32);
    drive_frame(1, 0, 1, -1);
    chk("verr_linecnt", oLineCnt, 32);
    chk("verr_sticky", oErrV, 1);
    chk("verr_done", oDone, 1);

    start(2);
    drive_frame(1, 0, 0, -1);
    lens.delete();
    drive_frame(1, 0, 1, -1);
    mk(32, 32);
    drive_frame(1, 1, 1, -1);
    chk("coinc_done", oDone, 1);
    chk("bound_sb_empty", sb.size(), 0);

    iHdisplay = 12'd3;
    iVdisplay = 12'd2;
    start(0);
    mk(2, 3);
    drive_frame(1, 0, 0, -1);
    repeat (260) drive_frame(1, 0, 1, -1);
    chk("cont_busy", oBusy, 1);
    chk("cont_fcnt", oFrameCnt, 4);
    chk("cont_pulses", npulse, 260);
    @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    iRst = 1'b1;

    iHdisplay = 12'd8;
    iVdisplay = 12'd6;
    start(4);
    mk(6, 8);
    drive_frame(1, 0, 0, -1);
    drive_frame(1, 0, 1, -1);
    drive_frame(1, 0, 0, 3);
    repeat (2) @(negedge iClk);
    iRst = 1'b1;
    chk("abort_sb_empty", sb.size(), 0);
    start(4);
    drive_frame(1, 0, 0, -1);
    drive_frame(1, 0, 1, -1);
    chk("abort_resync_pulses", npulse, 1);
    chk("abort_busy", oBusy, 1);
    chk("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
